// File: rtl/calc_sequencer.sv
// Control/sequencing front end for the 4-bit sign-magnitude calculator:
// captures operands on start, runs add/sub in one cycle or a shift-add multiply, returns registered result.
module calc_sequencer #(
  parameter int MUL_ITERS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic       signA,
  input  logic [3:0] B,
  input  logic       signB,
  input  logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] O,
  output logic       ovf,
  output logic       err
);

  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, FIN, DONE} state_t;

  state_t          state, next;
  logic [3:0]      a_mag, b_mag;
  logic            sa, sb;
  logic [1:0]      op;
  logic [7:0]      a_t, b_t;
  logic [7:0]      acc;
  logic [CW-1:0]   cnt;
  logic [7:0]      res;
  logic            err_pend;
  logic            prod_neg;

  function automatic logic [7:0] to_tc(input logic s, input logic [3:0] m);
    logic [7:0] z;
    z = {4'b0000, m};
    return s ? (~z + 8'd1) : z;
  endfunction

  // Negative zero product is forced positive
  assign prod_neg = (sa ^ sb) && (acc != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = LOAD;
      LOAD: next = EXEC;
      EXEC: begin
        if (op != OP_MUL || cnt == CW'(MUL_ITERS - 1)) next = FIN;
      end
      FIN:  next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag    <= '0;
      b_mag    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      op       <= '0;
      a_t      <= '0;
      b_t      <= '0;
      acc      <= '0;
      cnt      <= '0;
      res      <= '0;
      err_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      O        <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_mag <= A;
            b_mag <= B;
            sa    <= signA;
            sb    <= signB;
            op    <= sel;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          a_t      <= to_tc(sa, a_mag);
          b_t      <= to_tc(sb, b_mag);
          acc      <= '0;
          cnt      <= '0;
          res      <= '0;
          err_pend <= 1'b0;
        end
        EXEC: begin
          case (op)
            OP_ADD: res <= a_t + b_t;
            OP_SUB: res <= a_t - b_t;
            OP_MUL: begin
              // Shift-add on magnitudes; B is the multiplier
              if (b_mag[cnt]) acc <= acc + ({4'b0000, a_mag} << cnt);
              cnt <= cnt + 1'b1;
            end
            default: begin
              res      <= '0;
              err_pend <= 1'b1;
            end
          endcase
        end
        FIN: begin
          if (op == OP_MUL) begin
            O   <= prod_neg ? (~acc + 8'd1) : acc;
            ovf <= acc[7];
          end else begin
            O   <= res;
            ovf <= 1'b0;
          end
          err  <= err_pend;
          done <= 1'b1;
          busy <= 1'b0;
        end
        DONE: done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Clocked control and sequencing unit for the 4-bit sign-magnitude calculator datapath. It captures operands on a start/done handshake and converts sign-magnitude to 8-bit two's complement. Add/sub runs in a single execute cycle; multiply uses a 4-iteration shift-add on magnitudes. It returns a registered 8-bit two's-complement result with overflow/error flags and is the single front end to calculator arithmetic for the rest of the design.

Parameters:
MUL_ITERS, 4, shift-add iterations for multiply; equals operand magnitude width, fixed at 4 in this revision

Ports:
clk    input   1  system clock, rising edge
rst    input   1  asynchronous, active-high reset
start  input   1  request; sampled only in IDLE
A      input   4  operand A magnitude
signA  input   1  operand A sign (1 = negative)
B      input   4  operand B magnitude
signB  input   1  operand B sign (1 = negative)
sel    input   2  00 add (A+B), 01 sub (A-B), 10 mul (A*B), 11 reserved
busy   output  1  high from the edge that accepts start until the edge that asserts done
done   output  1  one-cycle completion pulse
O      output  8  result, two's complement, registered
ovf    output  1  result magnitude exceeded signed 8-bit range; valid with done, held until the next completion
err    output  1  reserved sel was issued; valid with done, held until the next completion

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, O=8'h00, ovf=0, err=0; all internal registers cleared. This applies at any point, including mid-multiply; the operation in progress is discarded and no done is issued.
- States: IDLE, LOAD, EXEC, FIN, DONE.
- IDLE: when start=1 at edge k, latch A, signA, B, signB and sel; go to LOAD; busy=1 after edge k.
- LOAD (edge k+1):
  - Form 8-bit two's-complement aT and bT: zero-extend the magnitude; negate when the sign bit is 1.
  - Negative zero (sign=1, magnitude=0) gives 0.
  - Clear the product accumulator and the iteration counter; go to EXEC.
- EXEC, add/sub: one edge (k+2). Compute aT+bT or aT-bT into the result register; go to FIN. The range is -30..+30, so ovf=0 always.
- EXEC, mul: MUL_ITERS edges (k+2..k+5), using unsigned magnitudes.
  - Each iteration: if multiplier bit [cnt] is 1, acc += mcand << cnt; then cnt++.
  - Leave EXEC on the edge where cnt reaches MUL_ITERS-1.
  - The product sign is signA XOR signB, forced to positive when the magnitude product is 0.
- EXEC, sel=11: one edge; result=0, err flag set; go to FIN.
- FIN (edge k+3 add/sub/reserved, k+6 mul):
  - Apply the sign (mul only) and write O.
  - ovf=1 iff the mul magnitude is >127; O is then the low 8 bits of the signed product.
  - Write err.
  - done=1, busy=0; go to DONE.
- DONE: done is high for exactly this one cycle. Next edge: done=0, return to IDLE.
- Latency from the start-sampling edge to the done-asserting edge: 3 cycles for add/sub/reserved, 6 for mul. Back-to-back throughput is one op per 5 (add/sub) or 8 (mul) cycles.
- start while busy=1 or in DONE: ignored, not queued. Input changes after capture do not affect the operation in progress.
- O, ovf and err hold their values between completions. They change only in FIN or on reset.
- Outputs are driven only from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Add: A=5,signA=0, B=3,signB=1, sel=00, start pulse at edge k -> done=1 after edge k+3, O=8'h02, ovf=0, err=0; busy=1 during k+1..k+2.
- Sub: A=7,signA=1, B=8,signB=0, sel=01 -> O=8'hF1 (-15) after 3 cycles. Also A=0,signA=1 (-0) minus B=0 -> O=8'h00.
- Mul: A=6,signA=1, B=5,signB=0, sel=10 -> done after edge k+6, O=8'hE2 (-30), ovf=0. Also 0 * -9 -> O=8'h00.
- Overflow and error: 15*15, both positive -> O=8'hE1, ovf=1. Next op sel=11 -> O=8'h00, err=1, ovf=0, done after 3 cycles.
- Handshake: re-pulse start at k+2 during a mul and change A -> ignored; exactly one done, with the original result. start held high continuously -> a new op is accepted each time IDLE is re-entered.
- Reset mid-op: assert rst asynchronously between clock edges at k+4 of a mul -> busy, done, O, ovf and err drop to 0 immediately. After release, no done occurs until a new start; a following add completes correctly.
